// File: rtl/ret_stack_ctrl_pkg.sv
// rtl/ret_stack_ctrl_pkg.sv - shared sizes, op encoding and pointer struct for the return stack
package ret_stack_ctrl_pkg;

  localparam int RS_DEPTH    = 16;
  localparam int RS_PTR_W    = $clog2(RS_DEPTH);
  localparam int RS_IP_WIDTH = 48;
  localparam logic [RS_PTR_W:0] RS_COUNT_MAX = RS_DEPTH[RS_PTR_W:0];

  // Encoding is {pop, push} so decode bits cast straight into an op
  typedef enum logic [1:0] {
    NONE    = 2'b00,
    PUSH    = 2'b01,
    POP     = 2'b10,
    POPPUSH = 2'b11
  } ret_op_t;

  typedef struct packed {
    logic [RS_PTR_W-1:0] tos;
    logic [RS_PTR_W:0]   count;
  } rs_ptr_t;

endpackage

// File: rtl/ret_stack_ctrl_if.sv
// rtl/ret_stack_ctrl_if.sv - decode, prediction and commit signals between front end and return stack
interface ret_stack_ctrl_if
  import ret_stack_ctrl_pkg::*;
#(
  parameter int IP_WIDTH = RS_IP_WIDTH
);

  logic [1:0]          dec_valid;
  logic [1:0]          dec_push;
  logic [1:0]          dec_pop;
  logic [IP_WIDTH-1:0] dec_ret_addr0;
  logic [IP_WIDTH-1:0] dec_ret_addr1;
  logic                dec_ready;
  logic [1:0]          pred_valid;
  logic [IP_WIDTH-1:0] pred_target0;
  logic [IP_WIDTH-1:0] pred_target1;
  logic [1:0]          cmt_valid;
  logic [1:0]          cmt_push;
  logic [1:0]          cmt_pop;

  modport master (
    output dec_valid, dec_push, dec_pop, dec_ret_addr0, dec_ret_addr1,
    output cmt_valid, cmt_push, cmt_pop,
    input  dec_ready, pred_valid, pred_target0, pred_target1
  );

  modport slave (
    input  dec_valid, dec_push, dec_pop, dec_ret_addr0, dec_ret_addr1,
    input  cmt_valid, cmt_push, cmt_pop,
    output dec_ready, pred_valid, pred_target0, pred_target1
  );

endinterface

// File: rtl/ret_stack_ptr_upd.sv
// rtl/ret_stack_ptr_upd.sv - next tos/count for one slot op; pop before push, pop at empty is a no-op
module ret_stack_ptr_upd
  import ret_stack_ctrl_pkg::*;
(
  input  rs_ptr_t curPtr,
  input  ret_op_t op,
  output rs_ptr_t nextPtr,
  output logic    underflow
);

  always_comb begin
    nextPtr   = curPtr;
    underflow = 1'b0;
    if (op == POP || op == POPPUSH) begin
      if (curPtr.count == '0) begin
        underflow = 1'b1;
      end else begin
        nextPtr.tos   = curPtr.tos - 1'b1;
        nextPtr.count = curPtr.count - 1'b1;
      end
    end
    // A push at full wraps onto the oldest entry, so only the count saturates
    if (op == PUSH || op == POPPUSH) begin
      nextPtr.tos = nextPtr.tos + 1'b1;
      if (nextPtr.count != RS_COUNT_MAX) begin
        nextPtr.count = nextPtr.count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ret_stack_ctrl.sv
// rtl/ret_stack_ctrl.sv - two-slot return address stack with speculative/committed pointers
// Optional RET_STACK_SHADOW_EN: committed shadow array restores entry contents on flush.
module ret_stack_ctrl
  import ret_stack_ctrl_pkg::*;
#(
  parameter int DEPTH    = RS_DEPTH,
  parameter int IP_WIDTH = RS_IP_WIDTH,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  ret_stack_ctrl_if.slave  rsIf,
  input  logic             flush,
  output logic [PTR_W:0]   spec_count,
  output logic             full,
  output logic             empty,
  output logic             underflow
);

  logic                accept;
  logic [1:0]          decPush, decPop, cmtPushV, cmtPopV;
  rs_ptr_t             specPtr, specMid, specNext, cmtPtr, cmtMid, cmtNext;
  ret_op_t             specOp0, specOp1, cmtOp0, cmtOp1;
  logic                specUf0, specUf1;
  logic [1:0]          unusedCmtUf;
  logic                predV0, predV1;
  logic [IP_WIDTH-1:0] target0, target1;
  logic [IP_WIDTH-1:0] entries [DEPTH];

  assign accept         = ~flush;
  assign rsIf.dec_ready = accept;

  assign decPush  = rsIf.dec_valid & rsIf.dec_push & {2{accept}};
  assign decPop   = rsIf.dec_valid & rsIf.dec_pop  & {2{accept}};
  assign cmtPushV = rsIf.cmt_valid & rsIf.cmt_push;
  assign cmtPopV  = rsIf.cmt_valid & rsIf.cmt_pop;

  assign specOp0 = ret_op_t'({decPop[0], decPush[0]});
  assign specOp1 = ret_op_t'({decPop[1], decPush[1]});
  assign cmtOp0  = ret_op_t'({cmtPopV[0], cmtPushV[0]});
  assign cmtOp1  = ret_op_t'({cmtPopV[1], cmtPushV[1]});

  ret_stack_ptr_upd specUpd0 (.curPtr(specPtr), .op(specOp0), .nextPtr(specMid),  .underflow(specUf0));
  ret_stack_ptr_upd specUpd1 (.curPtr(specMid), .op(specOp1), .nextPtr(specNext), .underflow(specUf1));
  ret_stack_ptr_upd cmtUpd0  (.curPtr(cmtPtr),  .op(cmtOp0),  .nextPtr(cmtMid),   .underflow(unusedCmtUf[0]));
  ret_stack_ptr_upd cmtUpd1  (.curPtr(cmtMid),  .op(cmtOp1),  .nextPtr(cmtNext),  .underflow(unusedCmtUf[1]));

  // Slot 1 reads after slot 0's op; a slot 0 push lands at specMid.tos, so bypass it
  assign predV0  = decPop[0] & ~specUf0;
  assign predV1  = decPop[1] & ~specUf1;
  assign target0 = entries[specPtr.tos];
  assign target1 = decPush[0] ? rsIf.dec_ret_addr0 : entries[specMid.tos];

  assign spec_count = specPtr.count;
  assign full       = (specPtr.count == RS_COUNT_MAX);
  assign empty      = (specPtr.count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      specPtr           <= '0;
      cmtPtr            <= '0;
      rsIf.pred_valid   <= '0;
      rsIf.pred_target0 <= '0;
      rsIf.pred_target1 <= '0;
      underflow         <= 1'b0;
    end else begin
      cmtPtr            <= cmtNext;
      specPtr           <= flush ? cmtNext : specNext;
      rsIf.pred_valid   <= {predV1, predV0};
      rsIf.pred_target0 <= predV0 ? target0 : '0;
      rsIf.pred_target1 <= predV1 ? target1 : '0;
      underflow         <= specUf0 | specUf1;
    end
  end

`ifdef RET_STACK_SHADOW_EN
  localparam int FIFO_W = PTR_W + 1;

  logic [IP_WIDTH-1:0] shadow   [DEPTH];
  logic [IP_WIDTH-1:0] pushFifo [2*DEPTH];
  logic [FIFO_W-1:0]   fifoWr, fifoRd, fifoRd1, fifoRdNext, fifoWr1;
  logic [IP_WIDTH-1:0] cmtAddr0, cmtAddr1;

  // Speculative push addresses queue up in program order; retiring calls drain them
  assign fifoRd1    = fifoRd + FIFO_W'(cmtPushV[0]);
  assign fifoRdNext = fifoRd1 + FIFO_W'(cmtPushV[1]);
  assign fifoWr1    = fifoWr + FIFO_W'(decPush[0]);
  assign cmtAddr0   = pushFifo[fifoRd];
  assign cmtAddr1   = pushFifo[fifoRd1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifoWr <= '0;
      fifoRd <= '0;
    end else begin
      fifoRd <= fifoRdNext;
      fifoWr <= flush ? fifoRdNext : fifoWr1 + FIFO_W'(decPush[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (decPush[0]) pushFifo[fifoWr]  <= rsIf.dec_ret_addr0;
    if (decPush[1]) pushFifo[fifoWr1] <= rsIf.dec_ret_addr1;
    if (cmtPushV[0]) shadow[cmtMid.tos]  <= cmtAddr0;
    if (cmtPushV[1]) shadow[cmtNext.tos] <= cmtAddr1;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cmtPushV[1] && cmtNext.tos == RS_PTR_W'(i)) entries[i] <= cmtAddr1;
        else if (cmtPushV[0] && cmtMid.tos == RS_PTR_W'(i)) entries[i] <= cmtAddr0;
        else entries[i] <= shadow[i];
      end
    end else begin
      if (decPush[0]) entries[specMid.tos]  <= rsIf.dec_ret_addr0;
      if (decPush[1]) entries[specNext.tos] <= rsIf.dec_ret_addr1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (decPush[0]) entries[specMid.tos]  <= rsIf.dec_ret_addr0;
    if (decPush[1]) entries[specNext.tos] <= rsIf.dec_ret_addr1;
  end
`endif

endmodule

// File: tb/tb_ret_stack_ctrl.sv
// tb/tb_ret_stack_ctrl.sv - directed self-checking bench for ret_stack_ctrl
module tb_ret_stack_ctrl;
  import ret_stack_ctrl_pkg::*;

  localparam int IPW = 48;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [RS_PTR_W:0] spec_count;
  logic            full, empty, underflow;
  int              checkCount = 0;
  int              errorCount = 0;

  ret_stack_ctrl_if #(.IP_WIDTH(IPW)) rsIf ();

  ret_stack_ctrl #(.DEPTH(RS_DEPTH), .IP_WIDTH(IPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rsIf      (rsIf),
    .flush     (flush),
    .spec_count(spec_count),
    .full      (full),
    .empty     (empty),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    rsIf.dec_valid     = '0;
    rsIf.dec_push      = '0;
    rsIf.dec_pop       = '0;
    rsIf.dec_ret_addr0 = '0;
    rsIf.dec_ret_addr1 = '0;
    rsIf.cmt_valid     = '0;
    rsIf.cmt_push      = '0;
    rsIf.cmt_pop       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decCycle(input logic [1:0] v, input logic [1:0] push, input logic [1:0] pop,
                          input logic [IPW-1:0] a0, input logic [IPW-1:0] a1);
    rsIf.dec_valid     = v;
    rsIf.dec_push      = push;
    rsIf.dec_pop       = pop;
    rsIf.dec_ret_addr0 = a0;
    rsIf.dec_ret_addr1 = a1;
    tick();
    clearIn();
  endtask

  task automatic checkPred(input string tag, input logic [1:0] pv,
                           input logic [IPW-1:0] t0, input logic [IPW-1:0] t1);
    checkEq({tag, "_pred_valid"}, 64'(rsIf.pred_valid), 64'(pv));
    checkEq({tag, "_target0"}, 64'(rsIf.pred_target0), 64'(t0));
    checkEq({tag, "_target1"}, 64'(rsIf.pred_target1), 64'(t1));
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    clearIn();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    checkEq("rst_count", 64'(spec_count), 0);
    checkEq("rst_empty", 64'(empty), 1);
    checkEq("rst_full", 64'(full), 0);
    checkEq("rst_dec_ready", 64'(rsIf.dec_ready), 1);
    checkEq("rst_underflow", 64'(underflow), 0);
    checkPred("rst", 2'b00, '0, '0);

    // 1: push then pop on slot 0
    decCycle(2'b01, 2'b01, 2'b00, 48'h1000, '0);
    checkEq("t1_count_push", 64'(spec_count), 1);
    checkEq("t1_pv_after_push", 64'(rsIf.pred_valid), 0);
    decCycle(2'b01, 2'b00, 2'b01, '0, '0);
    checkPred("t1", 2'b01, 48'h1000, '0);
    checkEq("t1_count_pop", 64'(spec_count), 0);

    // 2: slot 1 pop bypasses slot 0 push
    decCycle(2'b11, 2'b01, 2'b10, 48'h2000, '0);
    checkPred("t2", 2'b10, '0, 48'h2000);
    checkEq("t2_count", 64'(spec_count), 0);

    // 3: 17 pushes wrap the oldest entry, 16 pops return newest first
    for (int i = 0; i < 17; i++) begin
      decCycle(2'b01, 2'b01, 2'b00, 48'h100 + IPW'(i), '0);
      if (i == 14) checkEq("t3_not_full_15", 64'(full), 0);
      if (i == 15) checkEq("t3_full_16", 64'(full), 1);
      checkEq($sformatf("t3_count_push%0d", i), 64'(spec_count), (i < 16) ? i + 1 : 16);
    end
    for (int i = 0; i < 16; i++) begin
      decCycle(2'b01, 2'b00, 2'b01, '0, '0);
      checkPred($sformatf("t3_pop%0d", i), 2'b01, 48'h110 - IPW'(i), '0);
    end
    checkEq("t3_empty", 64'(empty), 1);
    decCycle(2'b01, 2'b00, 2'b01, '0, '0);
    checkPred("t3_pop17", 2'b00, '0, '0);
    checkEq("t3_underflow", 64'(underflow), 1);

    // 4: pop at empty pulses underflow for one cycle only
    decCycle(2'b01, 2'b00, 2'b01, '0, '0);
    checkEq("t4_underflow", 64'(underflow), 1);
    checkEq("t4_pv", 64'(rsIf.pred_valid), 0);
    checkEq("t4_count", 64'(spec_count), 0);
    tick();
    checkEq("t4_underflow_clear", 64'(underflow), 0);

    // 5: align to committed view, push A B C, commit A, flush with commit of B
    flush = 1'b1;
    #1 checkEq("t5_ready_flush0", 64'(rsIf.dec_ready), 0);
    tick();
    flush = 1'b0;
    checkEq("t5_count_flush0", 64'(spec_count), 0);
    decCycle(2'b01, 2'b01, 2'b00, 48'hA00, '0);
    decCycle(2'b01, 2'b01, 2'b00, 48'hB00, '0);
    decCycle(2'b01, 2'b01, 2'b00, 48'hC00, '0);
    checkEq("t5_count_abc", 64'(spec_count), 3);
    rsIf.cmt_valid = 2'b01;
    rsIf.cmt_push  = 2'b01;
    tick();
    clearIn();
    checkEq("t5_count_cmt", 64'(spec_count), 3);
    flush              = 1'b1;
    rsIf.cmt_valid     = 2'b01;
    rsIf.cmt_push      = 2'b01;
    rsIf.dec_valid     = 2'b01;
    rsIf.dec_push      = 2'b01;
    rsIf.dec_ret_addr0 = 48'hDEAD;
    #1 checkEq("t5_ready_flush", 64'(rsIf.dec_ready), 0);
    tick();
    clearIn();
    flush = 1'b0;
    checkEq("t5_count_restored", 64'(spec_count), 2);
    checkEq("t5_pv_after_flush", 64'(rsIf.pred_valid), 0);
    decCycle(2'b01, 2'b00, 2'b01, '0, '0);
    checkPred("t5_pop", 2'b01, 48'hB00, '0);
    checkEq("t5_count_pop", 64'(spec_count), 1);

    // 6: asynchronous reset mid-sequence
    for (int i = 0; i < 5; i++) decCycle(2'b01, 2'b01, 2'b00, 48'h600 + IPW'(i), '0);
    decCycle(2'b01, 2'b00, 2'b01, '0, '0);
    checkPred("t6_pre", 2'b01, 48'h604, '0);
    checkEq("t6_count_pre", 64'(spec_count), 5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkEq("t6_count_rst", 64'(spec_count), 0);
    checkEq("t6_empty_rst", 64'(empty), 1);
    checkPred("t6_rst", 2'b00, '0, '0);
    tick();
    rst = 1'b1;
    decCycle(2'b01, 2'b01, 2'b00, 48'h5555, '0);
    checkEq("t6_count_push", 64'(spec_count), 1);
    checkEq("t6_entry1", 64'(dut.entries[1]), 64'h5555);

    // 7: two pushes then two pops in single groups
    decCycle(2'b11, 2'b11, 2'b00, 48'h7000, 48'h7100);
    checkEq("t7_count_push", 64'(spec_count), 3);
    decCycle(2'b11, 2'b00, 2'b11, '0, '0);
    checkPred("t7_pop", 2'b11, 48'h7100, 48'h7000);
    checkEq("t7_count_pop", 64'(spec_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ret_stack_ctrl.md
Name: ret_stack_ctrl

Overview:
- Return-address stack controller driven by the jump decoders' pushCallStack/popCallStack outputs for two decode slots per cycle.
- Holds a circular stack of return IPs and supplies predicted return targets to fetch redirect.
- Keeps speculative and committed pointers so a pipeline flush restores the committed view.
- Sits between the decode stage and the front-end redirect logic.

Parameters:
DEPTH, 16, number of stack entries; must be a power of two, at least 4
IP_WIDTH, 48, width of return address
PTR_W, $clog2(DEPTH), width of the pointer and count fields

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
dec_valid  in  2  decode slot valid; slot 0 is older than slot 1
dec_push  in  2  per-slot pushCallStack
dec_pop  in  2  per-slot popCallStack
dec_ret_addr0  in  IP_WIDTH  slot 0 return address (call IP + length)
dec_ret_addr1  in  IP_WIDTH  slot 1 return address
dec_ready  out  1  decode group accepted this cycle
pred_valid  out  2  per-slot return prediction valid
pred_target0  out  IP_WIDTH  slot 0 predicted return target
pred_target1  out  IP_WIDTH  slot 1 predicted return target
cmt_valid  in  2  retiring slots, in program order
cmt_push  in  2  retiring call
cmt_pop  in  2  retiring return
flush  in  1  mispredict or exception; restore speculative state from committed state
spec_count  out  PTR_W+1  speculative occupancy
full  out  1  spec_count==DEPTH
empty  out  1  spec_count==0
underflow  out  1  pulse: a pop was applied at count 0

Behaviour:
- Reset, asynchronous on rst low:
  - spec_tos, cmt_tos, spec_count and cmt_count clear to 0.
  - pred_valid, pred_target*, underflow clear to 0.
  - dec_ready resets to 1.
  - Entry array is not reset.
- dec_ready = ~flush. A group is accepted when dec_ready is high; dec_valid is sampled only when accepted.
- Slot order: slot 0 is applied first, then slot 1 sees slot 0's effect in the same cycle.
  - Slot 1 pop after slot 0 push returns dec_ret_addr0 (bypass).
- Per slot, pop and push both set (indirect call via return): pop first, then push.
- Pop:
  - pred_target = entry[tos].
  - tos decrements modulo DEPTH.
  - count decrements.
  - pred_valid=1 if count>0 before the pop.
- Pop at count 0:
  - pred_valid=0 and pred_target=0.
  - tos and count are unchanged.
  - underflow pulses for one cycle.
- Push: tos increments modulo DEPTH, entry[tos] is written with the return address, and count increments.
- Push at count==DEPTH overwrites the oldest entry and count saturates at DEPTH.
- Prediction latency: 1 cycle. pred_* are registered and valid the cycle after acceptance.
- pred_valid is 0 for slots without a pop and in any cycle without acceptance.
- Commit side:
  - cmt_tos and cmt_count are updated with the same slot-ordered rules as the speculative side.
  - Underflow clamps at 0; there is no underflow pulse from commit.
  - Commit does not write the entry array.
- Flush:
  - Commit for the same cycle is applied first.
  - spec_tos/spec_count then load the post-commit cmt values.
  - Decode input is ignored that cycle and pred_valid=0 next cycle.
- Flush held for multiple cycles: dec_ready stays low; the state tracks commit each cycle.

Optional Feature:
RET_STACK_SHADOW_EN
- With the macro defined:
  - A second DEPTH x IP_WIDTH array holds committed contents.
  - Commit push writes the retired return address, taken from an internal 2*DEPTH FIFO of speculative push addresses in push order.
  - On flush the speculative array is overwritten from the shadow array, so restored contents exactly match the committed view.
- Without the macro:
  - Only pointers are restored.
  - Entries overwritten by wrong-path pushes remain corrupted.

Decomposition:
- Shared package:
  - RS_DEPTH and RS_PTR_W.
  - ret_op_t enum (NONE, PUSH, POP, POPPUSH).
  - rs_ptr_t struct {tos, count}.
- Sub-module ret_stack_ptr_upd:
  - Combinational; takes (rs_ptr_t, ret_op_t) and returns the next rs_ptr_t and an underflow flag.
  - Instanced 2x for the speculative chain and 2x for the commit chain.

Test Plan:
1. Reset release, then slot 0 push 0x1000 and next cycle slot 0 pop -> pred_valid=01, pred_target0=0x1000, spec_count back to 0.
2. Same cycle: slot 0 push 0x2000, slot 1 pop -> pred_valid=10, pred_target1=0x2000 (bypass), spec_count=0.
3. 17 pushes 0x100..0x110 then 16 pops -> targets 0x110 down to 0x101, full=1 after push 16, count never exceeds 16; 17th pop -> pred_valid=0, underflow=1.
4. Pop at empty -> pred_valid=0, underflow pulse 1 cycle, spec_count stays 0.
5. Push A,B,C, commit A only, then flush with cmt push of B the same cycle -> spec_count=2, dec_ready=0 that cycle; next pop yields B.
6. Assert rst low mid-sequence with count=5 -> all counts 0, pred_valid=0 immediately; first push after release lands in entry 1.
